// File: rtl/r_update_sequencer.sv
// Sweeps a row range through a fixed-latency update datapath and writes each result back in place.
// Latency: one row read per cycle from the cycle after start; write-back pipe_latency cycles later; done one cycle after the last write.
// Backpressure: none; the datapath must accept a row every cycle. The host gets the memory port only while the sequencer is idle.
module r_update_sequencer #(
    parameter int element_width = 64,
    parameter int no_of_units   = 8,
    parameter int address_width = 20,
    parameter int pipe_latency  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [address_width-1:0]               base_address,
    input  logic [address_width-1:0]               length,
    output logic                                   busy,
    output logic                                   done,
    input  logic                                   host_req,
    input  logic                                   host_we,
    input  logic [address_width-1:0]               host_addr,
    input  logic [no_of_units*element_width-1:0]   host_wdata,
    output logic                                   host_grant,
    output logic [address_width-1:0]               mem_read_address,
    input  logic [no_of_units*element_width-1:0]   mem_read_data,
    output logic                                   mem_write_enable,
    output logic [address_width-1:0]               mem_write_address,
    output logic [no_of_units*element_width-1:0]   mem_write_data,
    output logic                                   dp_valid,
    output logic [no_of_units*element_width-1:0]   dp_data,
    input  logic [no_of_units*element_width-1:0]   dp_result
);

    localparam int row_width = no_of_units * element_width;

    localparam logic [1:0] st_idle   = 2'd0;
    localparam logic [1:0] st_issue  = 2'd1;
    localparam logic [1:0] st_drain  = 2'd2;
    localparam logic [1:0] st_finish = 2'd3;

    // Marks the output stage of the write-back pipe; every other bit is still in flight.
    localparam logic [pipe_latency-1:0] last_stage = pipe_latency'(1) << (pipe_latency - 1);

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [address_width-1:0] rd_addr;
    logic [address_width-1:0] remaining;
    logic [pipe_latency-1:0]  pipe_vld;
    logic [address_width-1:0] pipe_addr [pipe_latency];

    logic issue_vld;
    logic last_row;
    logic write_back;
    logic pending_upstream;

    assign issue_vld        = (state == st_issue);
    assign last_row         = (remaining == address_width'(1));
    assign write_back       = pipe_vld[pipe_latency-1];
    assign pending_upstream = |(pipe_vld & ~last_stage);

    // Reset is folded in so the host cannot touch memory while the block is held in reset.
    assign host_grant = rst_n & host_req & (state == st_idle) & ~start;

    assign busy     = (state != st_idle);
    assign done     = (state == st_finish);
    assign dp_valid = issue_vld;
    assign dp_data  = issue_vld ? mem_read_data : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            st_idle: begin
                if (start) begin
                    state_nxt = (length != '0) ? st_issue : st_finish;
                end
            end
            st_issue: begin
                if (last_row) begin
                    state_nxt = st_drain;
                end
            end
            st_drain: begin
                if (write_back && !pending_upstream) begin
                    state_nxt = st_finish;
                end
            end
            default: state_nxt = st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= st_idle;
            rd_addr   <= '0;
            remaining <= '0;
        end else begin
            state <= state_nxt;
            if (state == st_idle && start) begin
                rd_addr   <= base_address;
                remaining <= length;
            end else if (issue_vld) begin
                rd_addr   <= rd_addr + address_width'(1);
                remaining <= remaining - address_width'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < pipe_latency; i++) begin
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= issue_vld;
            pipe_addr[0] <= rd_addr;
            for (int i = 1; i < pipe_latency; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    always_comb begin
        mem_read_address  = '0;
        mem_write_enable  = 1'b0;
        mem_write_address = '0;
        mem_write_data    = '0;
        if (host_grant) begin
            mem_read_address  = host_addr;
            mem_write_enable  = host_we;
            mem_write_address = host_addr;
            mem_write_data    = host_wdata;
        end else begin
            if (issue_vld) begin
                mem_read_address = rd_addr;
            end
            if (write_back) begin
                mem_write_enable  = 1'b1;
                mem_write_address = pipe_addr[pipe_latency-1];
                mem_write_data    = row_width'(dp_result);
            end
        end
    end

endmodule

// File: tb/tb_r_update_sequencer.sv
// Directed bench for r_update_sequencer: timing of a sweep, zero length, wrap, host arbitration, reset and ignored start.
module tb_r_update_sequencer;

    localparam int EW = 64;
    localparam int NU = 8;
    localparam int AW = 20;
    localparam int PL = 4;
    localparam int DW = EW * NU;
    localparam logic [DW-1:0] XMASK = {8{64'hA5A5_0F0F_3C3C_9696}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic [AW-1:0] length = '0;
    logic          busy, done;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_grant;
    logic [AW-1:0] mem_read_address;
    logic [DW-1:0] mem_read_data;
    logic          mem_write_enable;
    logic [AW-1:0] mem_write_address;
    logic [DW-1:0] mem_write_data;
    logic          dp_valid;
    logic [DW-1:0] dp_data;
    logic [DW-1:0] dp_result;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [AW-1:0] last_wr = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    r_update_sequencer #(
        .element_width(EW), .no_of_units(NU), .address_width(AW), .pipe_latency(PL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_address(base_address), .length(length),
        .busy(busy), .done(done), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_grant(host_grant), .mem_read_address(mem_read_address),
        .mem_read_data(mem_read_data), .mem_write_enable(mem_write_enable),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .dp_valid(dp_valid), .dp_data(dp_data), .dp_result(dp_result)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rowdat(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) begin
            r[i*32 +: 32] = {12'h0, a} + 32'(i);
        end
        return r;
    endfunction

    // Memory model and a fixed-latency datapath that XORs each row with a mask.
    assign mem_read_data = rowdat(mem_read_address);
    logic [DW-1:0] dly [PL];
    always @(posedge clk) begin
        dly[0] <= dp_data;
        for (int i = 1; i < PL; i++) dly[i] <= dly[i-1];
    end
    assign dp_result = dly[PL-1] ^ XMASK;

    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
        if (rst_n && mem_write_enable && !host_grant) begin
            wr_cnt++;
            last_wr = mem_write_address;
            chk("wb_data", mem_write_data, rowdat(mem_write_address) ^ XMASK);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int w0, d0;
        logic bad;
        logic [AW-1:0] wexp [4];
        wexp[0] = 20'hFFFFE; wexp[1] = 20'hFFFFF; wexp[2] = 20'h00000; wexp[3] = 20'h00001;

        // Reset state, with the host pushing for the port
        host_req = 1'b1; host_we = 1'b1; host_addr = 20'h55;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dp_valid", dp_valid, 1'b0);
        chk("rst_we", mem_write_enable, 1'b0);
        chk("rst_grant", host_grant, 1'b0);
        cyc(); cyc();
        host_req = 1'b0; host_we = 1'b0;
        rst_n = 1'b1;
        cyc();
        chk("idle_rd_addr", mem_read_address, 20'h0);

        // Basic sweep: base 10, length 3
        start = 1'b1; base_address = 20'd10; length = 20'd3;
        #1;
        chk("s1_busy_c0", busy, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            cyc();
            start = 1'b0;
            if (c >= 1 && c <= 3) begin
                chk("s1_dp_valid", dp_valid, 1'b1);
                chk("s1_rd_addr", mem_read_address, AW'(9 + c));
                chk("s1_dp_data", dp_data, rowdat(AW'(9 + c)));
            end else begin
                chk("s1_dp_valid_off", dp_valid, 1'b0);
            end
            if (c >= 5 && c <= 7) begin
                chk("s1_we", mem_write_enable, 1'b1);
                chk("s1_wr_addr", mem_write_address, AW'(5 + c));
            end else begin
                chk("s1_we_off", mem_write_enable, 1'b0);
            end
            chk("s1_done", done, (c == 8));
            chk("s1_busy", busy, (c <= 8));
        end

        // Zero-length sweep
        w0 = wr_cnt; d0 = done_cnt;
        start = 1'b1; base_address = 20'd40; length = 20'd0;
        cyc();
        start = 1'b0;
        chk("z_done", done, 1'b1);
        chk("z_busy", busy, 1'b1);
        chk("z_dp_valid", dp_valid, 1'b0);
        cyc();
        chk("z_busy_after", busy, 1'b0);
        chk("z_done_after", done, 1'b0);
        cyc();
        chk("z_writes", wr_cnt, w0);
        chk("z_done_cnt", done_cnt, d0 + 1);

        // Address wrap at the top of the space
        start = 1'b1; base_address = 20'hFFFFE; length = 20'd4;
        for (int c = 1; c <= 9; c++) begin
            cyc();
            start = 1'b0;
            if (c <= 4) chk("wrap_rd_addr", mem_read_address, wexp[c-1]);
            if (c >= 5 && c <= 8) chk("wrap_wr_addr", mem_write_address, wexp[c-5]);
        end
        chk("wrap_done", done, 1'b1);
        cyc();

        // Host request in the same cycle as start: start wins for the whole sweep
        host_req = 1'b1; host_we = 1'b1; host_addr = 20'h00ABC; host_wdata = XMASK ^ rowdat(20'h3);
        start = 1'b1; base_address = 20'd50; length = 20'd2;
        #1;
        chk("h_grant_c0", host_grant, 1'b0);
        bad = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            start = 1'b0;
            if (host_grant) bad = 1'b1;
        end
        chk("h_done_c7", done, 1'b1);
        chk("h_no_grant_busy", bad, 1'b0);
        cyc();
        chk("h_grant_after", host_grant, 1'b1);
        chk("h_rd_addr", mem_read_address, 20'h00ABC);
        chk("h_we", mem_write_enable, 1'b1);
        chk("h_wr_addr", mem_write_address, 20'h00ABC);
        chk("h_wr_data", mem_write_data, XMASK ^ rowdat(20'h3));
        host_req = 1'b0; host_we = 1'b0;
        cyc();
        chk("h_grant_drop", host_grant, 1'b0);

        // Reset in the middle of a length-8 sweep
        start = 1'b1; base_address = 20'd100; length = 20'd8;
        cyc();
        start = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        chk("mr_busy", busy, 1'b0);
        chk("mr_dp_valid", dp_valid, 1'b0);
        chk("mr_we", mem_write_enable, 1'b0);
        chk("mr_done", done, 1'b0);
        chk("mr_rd_addr", mem_read_address, 20'h0);
        cyc(); cyc();
        rst_n = 1'b1;
        w0 = wr_cnt; d0 = done_cnt;
        repeat (15) cyc();
        chk("mr_no_writes", wr_cnt, w0);
        chk("mr_no_done", done_cnt, d0);
        chk("mr_idle", busy, 1'b0);

        // Second start during ISSUE is ignored
        w0 = wr_cnt; d0 = done_cnt;
        start = 1'b1; base_address = 20'd200; length = 20'd5;
        cyc();
        start = 1'b0;
        cyc();
        start = 1'b1; base_address = 20'd300; length = 20'd9;
        cyc();
        start = 1'b0;
        repeat (20) cyc();
        chk("ds_writes", wr_cnt - w0, 5);
        chk("ds_dones", done_cnt - d0, 1);
        chk("ds_last_addr", last_wr, 20'd204);
        chk("ds_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/r_update_sequencer.md
R_UPDATE_SEQUENCER -- requirements
Module: r_update_sequencer

Interface
REQ-001 Parameter element_width, default 64, bit width of one vector element.
REQ-002 Parameter no_of_units, default 8, number of elements per memory word.
REQ-003 Parameter address_width, default 20, memory address width.
REQ-004 Parameter pipe_latency, default 4, fixed cycles from dp_valid to matching dp_result (range 1..15).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle pulse that begins a sweep.
REQ-008 base_address  input  address_width  first row of the sweep, sampled on start.
REQ-009 length  input  address_width  number of rows in the sweep, sampled on start.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  one-cycle pulse at sweep completion.
REQ-012 host_req  input  1  host requests the memory port.
REQ-013 host_we  input  1  host write strobe, qualified by host_grant.
REQ-014 host_addr  input  address_width  host read/write address.
REQ-015 host_wdata  input  no_of_units*element_width  host write data.
REQ-016 host_grant  output  1  host owns the memory port this cycle.
REQ-017 mem_read_address  output  address_width  memory read address.
REQ-018 mem_read_data  input  no_of_units*element_width  combinational memory read data.
REQ-019 mem_write_enable, mem_write_address, mem_write_data  output  1 / address_width / no_of_units*element_width  memory write port.
REQ-020 dp_valid, dp_data  output  1 / no_of_units*element_width  row issued to the update datapath.
REQ-021 dp_result  input  no_of_units*element_width  datapath result, valid exactly pipe_latency cycles after its dp_valid.

Function
REQ-022 The block SHALL implement states IDLE, ISSUE, DRAIN, FINISH.
REQ-023 IDLE: start=1 with length>0 SHALL latch base_address/length and go to ISSUE next cycle; start with length=0 SHALL go straight to FINISH.
REQ-024 ISSUE: each cycle SHALL drive mem_read_address = base+k, dp_data = mem_read_data, dp_valid=1, for k=0..length-1, one row per cycle, no bubbles.
REQ-025 After issuing row length-1 the block SHALL enter DRAIN.
REQ-026 Each issued address SHALL travel through a pipe_latency-deep address/valid shift register; mem_write_enable=1, mem_write_address=delayed address, mem_write_data=dp_result when the delayed valid is set.
REQ-027 DRAIN SHALL go to FINISH on the cycle after the last write-back is performed.
REQ-028 FINISH SHALL assert done for one cycle and return to IDLE.
REQ-029 busy SHALL be 1 in ISSUE, DRAIN and FINISH, 0 in IDLE.
REQ-030 Addresses SHALL wrap modulo 2^address_width (base+k truncated).
REQ-031 start while busy SHALL be ignored; latched base/length unchanged.
REQ-032 host_grant SHALL equal host_req AND state==IDLE AND NOT start; start wins a same-cycle conflict with host_req.
REQ-033 When host_grant=1 the memory ports SHALL mux to host: read address = host_addr, write enable = host_we, write address/data = host_addr/host_wdata.
REQ-034 When no owner, mem_write_enable SHALL be 0 and mem_read_address SHALL be 0.
REQ-035 dp_valid SHALL be 0 outside ISSUE.

Reset
REQ-036 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, dp_valid=0, mem_write_enable=0, host_grant=0, and clear the valid shift register.
REQ-037 Reset mid-sweep SHALL discard all in-flight write-backs; no write may occur after reset release until a new start or host grant.

Verification
REQ-038 base=10, length=3, pipe_latency=4: reads addresses 10,11,12 on cycles 1-3 after start; writes 10,11,12 on cycles 5-7; done on cycle 8.
REQ-039 length=0 start -> no dp_valid, no write, done one cycle after start, busy high one cycle.
REQ-040 base=2^20-2, length=4 -> read/write addresses FFFFE, FFFFF, 00000, 00001.
REQ-041 host_req held with start on the same cycle -> host_grant=0 for the entire sweep, host_grant=1 the cycle after done.
REQ-042 rst_n pulsed low two cycles after start of length 8 -> outputs zero during reset, no mem_write_enable afterwards, state IDLE.
REQ-043 Second start pulse during ISSUE -> ignored; exactly one done, write count equals first length.
